rx_oversampler: RTL and testbench
=================================

# rx_oversampler

Front end of the receive path. Synchronises the serial line, detects a start bit, and oversamples the eight data bits at ten samples per bit into an 80-bit vector. It then releases the vector to `sample_decoder` by dropping `sample_flag`. The decoder majority-votes each 10-sample window on that falling edge, so this block owns frame alignment, sample ordering and the flag timing.

## Interface
- `CLKS_PER_SAMPLE`, default 16: clk cycles per sample tick (oversample period); legal values are ≥2.
- `SAMPLES_PER_BIT`, default 10: fixed; must match the decoder.
- `DATA_BITS`, default 8: fixed; `SAMPLE_W` = `DATA_BITS`*`SAMPLES_PER_BIT` = 80.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_in` input 1: asynchronous serial line; idles high; start bit is low; data is LSB first; one stop bit is high.
- `sample_flag` output 1: high while a frame is being captured; its falling edge means `sample` is complete and stable.
- `sample` output 80: captured samples; `sample[k]` is the k-th data sample in time order.
- `framing_err` output 1: registered status of the last frame's stop bit; 1 means the stop bit was bad.

## Operation
- `rx_in` passes through a 2-flop synchroniser, giving `rx_s`. A previous-value flop gives `rx_fall` = previous & ~`rx_s`.
- Tick counter `tcnt` counts 0..`CLKS_PER_SAMPLE`-1. `tick` = (`tcnt`==`CLKS_PER_SAMPLE`-1). `tcnt` is forced to 0 on the cycle `rx_fall` is accepted in IDLE.
- Sample counter `scnt` is 7 bits and advances only on `tick`.
- States and transitions:
  - IDLE → START on `rx_fall`. Clear `scnt`. Any `rx_fall` outside IDLE is ignored.
  - START: count 10 ticks, summing low samples of `rx_s` into `lowcnt`. At the 10th tick, go to CAPTURE (subject to the Configuration macro).
  - CAPTURE: on each `tick`, write `sample[scnt]` ← `rx_s` and increment `scnt`. On the tick with `scnt`==79, write `sample[79]`, clear `scnt`, and go to RELEASE.
  - RELEASE: lasts exactly one clk. `sample_flag` ← 0. Go to STOP.
  - STOP: count 10 ticks, summing high samples. At the 10th tick, set `framing_err` ← (highs < 5), clear `scnt`, and go to IDLE.
- `sample_flag` is registered. It goes to 1 on the clk edge of the first CAPTURE tick and to 0 on the edge leaving RELEASE.
- `sample` is written only in CAPTURE. It holds its value through STOP, IDLE and START of the next frame, until the first CAPTURE write of that frame.
- Ordering: data bit i occupies `sample[10i+9:10i]`, which matches the decoder windows.

## Timing
- Reset values: state IDLE; synchroniser and previous flops = 1 (line idle); `tcnt`=0; `scnt`=0; `sample_flag`=0; `sample`=80'h0; `framing_err`=0.
- Input latency: 2 clk through the synchroniser plus 1 clk for edge detect.
- `sample_flag` high time = 79*`CLKS_PER_SAMPLE`+1 clk.
  - The last `sample` write is always ≥1 clk before the flag falls. This avoids a race with the decoder's negedge.
- Earliest accepted next start edge: the first `rx_fall` after returning to IDLE at the end of STOP.
- Reset mid-capture: all state clears asynchronously and `sample_flag` drops immediately.
  - The decoder then decodes an all-zero `sample` (code 8'h00). This is the accepted behaviour.
  - No partial frame is resumed after reset.

## Configuration
- `RX_START_VALIDATE_EN` defined: at the end of START, if `lowcnt` < 5, the start is false.
  - Return to IDLE with no `sample_flag` pulse.
  - `sample` and `framing_err` are unchanged.
- Not defined: START always proceeds to CAPTURE after 10 ticks, and `lowcnt` logic is not built.

## Structure
- Shared package `rx_pkg` holds:
  - the state enum (IDLE, START, CAPTURE, RELEASE, STOP);
  - `SAMPLES_PER_BIT`=10, `DATA_BITS`=8, `SAMPLE_W`=80;
  - the majority threshold constant 5.
- One sub-module, `rx_sync`: 2-flop synchroniser plus falling-edge detect, reset to 1.
- Tick counter, sample counter and FSM stay in `rx_oversampler`.

## Test plan
Benches use `CLKS_PER_SAMPLE`=4.
- Clean frame 0xA5 (start, data LSB first, stop) → `sample[9:0]`=10'h3FF and `sample[19:10]`=10'h000; flag high for 317 clk; downstream decoder outputs 8'hA5; `framing_err`=0.
- Same frame with 3 samples of bit 2 flipped → decoder still outputs 8'hA5.
- Stop bit held low for the full bit time → `framing_err`=1 after STOP. The next clean frame 0x3C clears it to 0 and decodes 8'h3C.
- Glitch start (low for 3 samples, then high), with `RX_START_VALIDATE_EN` defined → no flag pulse, `sample` unchanged. Without the macro → one flag pulse, and the frame decodes as 8'hFF.
- `rst_n` asserted at sample 40 of a frame → flag=0 and `sample`=0 in the same cycle. After release, an idle line produces no flag.
- Back-to-back frames 0x01 then 0xFE with no idle gap → two flag pulses, decoded in order as 8'h01 then 8'hFE.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the receive front end: FSM states, frame geometry
// and the majority threshold used for start/stop validation.
package rx_pkg;

    localparam int SAMPLES_PER_BIT = 10;
    localparam int DATA_BITS       = 8;
    localparam int SAMPLE_W        = DATA_BITS * SAMPLES_PER_BIT;
    localparam int MAJORITY        = 5;
    localparam int SCNT_W          = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CAPTURE,
        RELEASE,
        STOP
    } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a
// previous-value flop for falling-edge detection. All flops reset to 1 so
// the line looks idle straight out of reset.
module rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_rx_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronise the line and keep last cycle's value for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s    = r_sync;
    assign o_rx_fall = r_prev & ~r_sync;

endmodule

// File: rtl/rx_oversampler.sv
// Receive front end: detects a start bit, oversamples eight data bits at ten
// samples per bit into an 80-bit vector and hands it to the decoder on the
// falling edge of o_sample_flag. Checks the stop bit by majority.
// Optional build macro RX_START_VALIDATE_EN: reject start bits whose window
// holds fewer than five low samples (glitch filter).
module rx_oversampler
    import rx_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx_in,
    output logic                o_sample_flag,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_framing_err
);

    localparam int TCNT_W = $clog2(CLKS_PER_SAMPLE);
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [SCNT_W-1:0] WIN_LAST   = SCNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [SCNT_W-1:0] FRAME_LAST = SCNT_W'(SAMPLE_W - 1);

    rx_state_e r_state;
    rx_state_e w_next_state;

    logic              w_rx_s;
    logic              w_rx_fall;
    logic              w_tick;
    logic              w_window_end;
    logic              w_frame_end;
    logic              w_start_ok;
    logic [TCNT_W-1:0] r_tcnt;
    logic [SCNT_W-1:0] r_scnt;
    logic [3:0]        r_highcnt;
    logic [3:0]        w_highs_total;

    logic w_accept;
    logic w_scnt_clr;
    logic w_scnt_inc;
    logic w_sample_wr;
    logic w_flag_set;
    logic w_flag_clr;
    logic w_stop_acc;
    logic w_stop_clr;
    logic w_ferr_load;

`ifdef RX_START_VALIDATE_EN
    logic [3:0] r_lowcnt;
    logic [3:0] w_lows_total;
    logic       w_start_acc;
`endif

    rx_sync u_sync (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rx      (i_rx_in),
        .o_rx_s    (w_rx_s),
        .o_rx_fall (w_rx_fall)
    );

    assign w_tick        = (r_tcnt == TCNT_LAST);
    assign w_window_end  = w_tick && (r_scnt == WIN_LAST);
    assign w_frame_end   = w_tick && (r_scnt == FRAME_LAST);
    assign w_highs_total = r_highcnt + {3'b000, w_rx_s};

`ifdef RX_START_VALIDATE_EN
    assign w_lows_total = r_lowcnt + {3'b000, ~w_rx_s};
    assign w_start_ok   = (w_lows_total >= 4'(MAJORITY));
`else
    assign w_start_ok   = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: every phase is paced by sample ticks
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_rx_fall)    w_next_state = START;
            START:   if (w_window_end) w_next_state = w_start_ok ? CAPTURE : IDLE;
            CAPTURE: if (w_frame_end)  w_next_state = RELEASE;
            RELEASE:                   w_next_state = STOP;
            STOP:    if (w_window_end) w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
    end

    // Output decode: per-state strobes driving the datapath registers
    always_comb begin
        w_accept    = 1'b0;
        w_scnt_clr  = 1'b0;
        w_scnt_inc  = 1'b0;
        w_sample_wr = 1'b0;
        w_flag_set  = 1'b0;
        w_flag_clr  = 1'b0;
        w_stop_acc  = 1'b0;
        w_stop_clr  = 1'b0;
        w_ferr_load = 1'b0;
`ifdef RX_START_VALIDATE_EN
        w_start_acc = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_accept   = w_rx_fall;
                w_scnt_clr = w_rx_fall;
            end
            START: begin
`ifdef RX_START_VALIDATE_EN
                w_start_acc = w_tick;
`endif
                if (w_window_end) w_scnt_clr = 1'b1;
                else              w_scnt_inc = w_tick;
            end
            CAPTURE: begin
                w_sample_wr = w_tick;
                w_flag_set  = w_tick && (r_scnt == '0);
                if (w_frame_end) w_scnt_clr = 1'b1;
                else             w_scnt_inc = w_tick;
            end
            RELEASE: begin
                w_flag_clr = 1'b1;
                w_stop_clr = 1'b1;
            end
            STOP: begin
                w_stop_acc = w_tick;
                if (w_window_end) begin
                    w_scnt_clr  = 1'b1;
                    w_ferr_load = 1'b1;
                end else begin
                    w_scnt_inc = w_tick;
                end
            end
            default: ;
        endcase
    end

    // Tick counter; the accept cycle itself is count 0, so restart at 1 so
    // each tick lands on the last clk of a sample period and the final stop
    // tick finishes in time for a back-to-back start edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
        end else if (w_accept) begin
            r_tcnt <= TCNT_W'(1);
        end else if (w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

    // Sample counter: ticks within a bit window, or sample index in CAPTURE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scnt <= '0;
        end else if (w_scnt_clr) begin
            r_scnt <= '0;
        end else if (w_scnt_inc) begin
            r_scnt <= r_scnt + SCNT_W'(1);
        end
    end

    // Sample vector: written only while capturing, held otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample <= '0;
        end else if (w_sample_wr) begin
            o_sample[r_scnt] <= w_rx_s;
        end
    end

    // Flag rises with the first capture write and falls one clk after the last
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample_flag <= 1'b0;
        end else if (w_flag_set) begin
            o_sample_flag <= 1'b1;
        end else if (w_flag_clr) begin
            o_sample_flag <= 1'b0;
        end
    end

    // Stop-bit high count and the registered framing verdict
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_highcnt     <= '0;
            o_framing_err <= 1'b0;
        end else begin
            if (w_stop_clr) begin
                r_highcnt <= '0;
            end else if (w_stop_acc) begin
                r_highcnt <= w_highs_total;
            end
            if (w_ferr_load) begin
                o_framing_err <= (w_highs_total < 4'(MAJORITY));
            end
        end
    end

`ifdef RX_START_VALIDATE_EN
    // Start-bit low count used to reject glitch starts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lowcnt <= '0;
        end else if (w_accept) begin
            r_lowcnt <= '0;
        end else if (w_start_acc) begin
            r_lowcnt <= w_lows_total;
        end
    end
`endif

endmodule

// File: tb/tb_rx_oversampler.sv
// Randomised self-checking bench for rx_oversampler. The line is driven one
// sample period at a time from a 100-slot frame picture; the expected sample
// vector, decoded byte, flag width and framing verdict come from that picture.
module tb_rx_oversampler;

    localparam int CPS = 4;

    logic        clk;
    logic        rstN;
    logic        rxLine;
    logic        flagOut;
    logic [79:0] sampleOut;
    logic        ferrOut;

    typedef struct {
        logic [79:0] samples;
        logic [7:0]  data;
    } frame_t;

    frame_t      expQ[$];
    int          totalChecks    = 0;
    int          badChecks      = 0;
    int          pulseCount     = 0;
    int          expectedPulses = 0;
    int          highCnt        = 0;
    bit          prevFlag       = 1'b0;
    logic [79:0] lastSamples    = '0;
    logic        expFerr        = 1'b0;

    rx_oversampler #(.CLKS_PER_SAMPLE(CPS)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_rx_in       (rxLine),
        .o_sample_flag (flagOut),
        .o_sample      (sampleOut),
        .o_framing_err (ferrOut)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count a comparison and report any difference
    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference decoder: majority of ten samples per data bit
    function automatic logic [7:0] decodeSamples(input logic [79:0] v);
        logic [7:0] r;
        int ones;
        r = '0;
        for (int w = 0; w < 8; w++) begin
            ones = 0;
            for (int j = 0; j < 10; j++) ones += int'(v[10*w+j]);
            r[w] = (ones >= 5);
        end
        return r;
    endfunction

    // Line picture of one frame in sample periods: 10 start, 80 data, 10 stop
    function automatic logic [99:0] buildFrame(input logic [7:0] data, input logic [79:0] flips, input logic [9:0] stopBits);
        logic [99:0] s;
        s = '0;
        for (int k = 0; k < 80; k++) s[10+k] = data[k/10] ^ flips[k];
        s[99:90] = stopBits;
        return s;
    endfunction

    // Up to maxPerWindow corrupted samples in each data bit window
    function automatic logic [79:0] randomFlips(input int maxPerWindow);
        logic [79:0] f;
        int n;
        f = '0;
        for (int w = 0; w < 8; w++) begin
            n = $urandom_range(maxPerWindow, 0);
            for (int j = 0; j < n; j++) f[10*w + $urandom_range(9, 0)] = 1'b1;
        end
        return f;
    endfunction

    // Decoder-side monitor: on each flag fall, check the released frame
    always @(negedge clk) begin
        frame_t e;
        if (!rstN) begin
            prevFlag = 1'b0;
            highCnt  = 0;
        end else begin
            if (flagOut) highCnt++;
            if (prevFlag && !flagOut) begin
                pulseCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", 80'd1, 80'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sample_vec", sampleOut, e.samples);
                    checkOutput("decoded", 80'(decodeSamples(sampleOut)), 80'(e.data));
                    checkOutput("flag_width", 80'(highCnt), 80'(79*CPS+1));
                end
                highCnt = 0;
            end
            prevFlag = flagOut;
        end
    end

    // Drive one frame picture; optionally settle and check status afterwards
    task automatic applyStimulus(input string name, input logic [99:0] slots, input logic [7:0] data,
                                 input bit expectPulse, input bit checkErr);
        frame_t e;
        if (expectPulse) begin
            e.samples = slots[89:10];
            e.data    = data;
            expQ.push_back(e);
            expectedPulses++;
            lastSamples = slots[89:10];
            expFerr     = ($countones(slots[99:90]) < 5);
        end
        for (int i = 0; i < 100; i++) begin
            rxLine = slots[i];
            repeat (CPS) @(negedge clk);
        end
        if (checkErr) begin
            rxLine = 1'b1;
            repeat (6) @(negedge clk);
            checkOutput({name, "_ferr"}, 80'(ferrOut), 80'(expFerr));
            checkOutput({name, "_pulses"}, 80'(pulseCount), 80'(expectedPulses));
            checkOutput({name, "_held"}, sampleOut, lastSamples);
        end
    endtask

    initial begin
        logic [99:0] slots;
        logic [99:0] glitch;
        logic [7:0]  data;
        logic [9:0]  stopBits;

        rstN   = 1'b0;
        rxLine = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_flag", 80'(flagOut), 80'd0);
        checkOutput("reset_sample", sampleOut, 80'd0);
        checkOutput("reset_ferr", 80'(ferrOut), 80'd0);
        rstN = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 0xA5
        applyStimulus("clean_a5", buildFrame(8'hA5, '0, 10'h3FF), 8'hA5, 1'b1, 1'b1);
        checkOutput("a5_bit0_window", 80'(sampleOut[9:0]), 80'h3FF);
        checkOutput("a5_bit1_window", 80'(sampleOut[19:10]), 80'h000);

        // 0xA5 with three samples of bit 2 corrupted
        slots = buildFrame(8'hA5, 80'h0 | (80'd1 << 20) | (80'd1 << 23) | (80'd1 << 27), 10'h3FF);
        applyStimulus("noisy_a5", slots, 8'hA5, 1'b1, 1'b1);

        // Stop bit low for the whole bit time, then a clean 0x3C clears it
        applyStimulus("bad_stop", buildFrame(8'h5A, '0, 10'h000), 8'h5A, 1'b1, 1'b1);
        applyStimulus("clean_3c", buildFrame(8'h3C, '0, 10'h3FF), 8'h3C, 1'b1, 1'b1);

        // Glitch start: three low samples then a high line
        glitch      = '1;
        glitch[2:0] = 3'b000;
`ifdef RX_START_VALIDATE_EN
        applyStimulus("glitch", glitch, 8'hFF, 1'b0, 1'b1);
`else
        applyStimulus("glitch", glitch, 8'hFF, 1'b1, 1'b1);
`endif

        // Back-to-back frames with no idle gap
        applyStimulus("b2b_01", buildFrame(8'h01, '0, 10'h3FF), 8'h01, 1'b1, 1'b0);
        applyStimulus("b2b_fe", buildFrame(8'hFE, '0, 10'h3FF), 8'hFE, 1'b1, 1'b1);

        // Randomised frames: data, sample noise, stop quality, idle gaps
        for (int n = 0; n < 8; n++) begin
            data     = 8'($urandom_range(255, 0));
            stopBits = ($urandom_range(1, 0) == 1) ? 10'h3FF : 10'($urandom);
            applyStimulus("rand", buildFrame(data, randomFlips(4), stopBits), data, 1'b1, 1'b1);
            rxLine = 1'b1;
            repeat ($urandom_range(20, 0)) @(negedge clk);
        end

        // Reset in the middle of a capture
        slots = buildFrame(8'h96, '0, 10'h3FF);
        for (int i = 0; i < 51; i++) begin
            rxLine = slots[i];
            repeat (CPS) @(negedge clk);
        end
        checkOutput("mid_frame_flag", 80'(flagOut), 80'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("reset_async_flag", 80'(flagOut), 80'd0);
        checkOutput("reset_async_sample", sampleOut, 80'd0);
        rxLine      = 1'b1;
        lastSamples = '0;
        expFerr     = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (400) @(negedge clk);
        checkOutput("idle_after_reset_pulses", 80'(pulseCount), 80'(expectedPulses));
        checkOutput("idle_after_reset_sample", sampleOut, 80'd0);

        // Recovery frame after reset
        applyStimulus("after_reset", buildFrame(8'h5A, randomFlips(3), 10'h3FF), 8'h5A, 1'b1, 1'b1);
        checkOutput("queue_drained", 80'(expQ.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
